// File: rtl/addsub_share_arb.sv
// addsub_share_arb
//   Shares one W-bit add/subtract datapath between NREQ requesters. A
//   round-robin arbiter picks one valid requester per cycle. Its result
//   (with carry/no-borrow and requester tag) is captured in a single output
//   register that supports backpressure.
//
// Ports
//   CLK, ASYNCRESETN    clock, asynchronous active-low reset
//   REQ_VALID/READY     per-requester handshake (one bit per requester)
//   REQ_OP              per-requester op: 0 = add, 1 = subtract (I0 - I1)
//   REQ_I0/REQ_I1       packed operands, requester i at [i*W +: W]
//   O_VALID/O_READY     result handshake
//   O, O_COUT, O_TAG    result, carry out (subtract: 1 = no borrow), source
//   OP_CNT              saturating count of accepted operations
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | result register empty, O_VALID = 0
// ST_FULL  | result register holds a result, O_VALID = 1
module addsub_share_arb #(
    parameter int W    = 8,
    parameter int NREQ = 4,
    parameter int TAGW = 2,
    parameter int CNTW = 16
) (
    input  logic              CLK,
    input  logic              ASYNCRESETN,
    input  logic [NREQ-1:0]   REQ_VALID,
    output logic [NREQ-1:0]   REQ_READY,
    input  logic [NREQ-1:0]   REQ_OP,
    input  logic [NREQ*W-1:0] REQ_I0,
    input  logic [NREQ*W-1:0] REQ_I1,
    output logic              O_VALID,
    input  logic              O_READY,
    output logic [W-1:0]      O,
    output logic              O_COUT,
    output logic [TAGW-1:0]   O_TAG,
    output logic [CNTW-1:0]   OP_CNT
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [TAGW-1:0] r_ptr;
    logic [TAGW-1:0] w_ptr_nxt;
    logic [TAGW-1:0] w_gnt;
    logic            w_found;
    logic            w_can_accept;
    logic            w_hs;
    logic [W-1:0]    w_a;
    logic [W-1:0]    w_b;
    logic            w_op;
    logic [W:0]      w_sum;
    logic [W-1:0]    r_o;
    logic            r_cout;
    logic [TAGW-1:0] r_tag;
    logic [CNTW-1:0] r_op_cnt;

    // Round-robin search: first valid requester at or after the pointer.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_gnt   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = int'(r_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!w_found && REQ_VALID[idx]) begin
                w_found = 1'b1;
                w_gnt   = TAGW'(idx);
            end
        end
    end

    assign w_can_accept = (r_state == ST_EMPTY) || O_READY;
    // Reset term keeps READY low while reset is held, independent of O_READY.
    assign w_hs         = w_found && w_can_accept && ASYNCRESETN;
    assign REQ_READY    = w_hs ? (NREQ'(1) << w_gnt) : '0;
    assign w_ptr_nxt    = (int'(w_gnt) == NREQ - 1) ? '0 : w_gnt + 1'b1;

    // Subtract is I0 + ~I1 + 1; bit W is carry, i.e. "no borrow" for subtract.
    assign w_op  = REQ_OP[w_gnt];
    assign w_a   = REQ_I0[int'(w_gnt)*W +: W];
    assign w_b   = w_op ? ~REQ_I1[int'(w_gnt)*W +: W] : REQ_I1[int'(w_gnt)*W +: W];
    assign w_sum = {1'b0, w_a} + {1'b0, w_b} + (W+1)'(w_op);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_hs) w_state_nxt = ST_FULL;
            ST_FULL: begin
                if (w_hs)         w_state_nxt = ST_FULL;
                else if (O_READY) w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            r_state  <= ST_EMPTY;
            r_o      <= '0;
            r_cout   <= 1'b0;
            r_tag    <= '0;
            r_ptr    <= '0;
            r_op_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_hs) begin
                r_o    <= w_sum[W-1:0];
                r_cout <= w_sum[W];
                r_tag  <= w_gnt;
                r_ptr  <= w_ptr_nxt;
                if (r_op_cnt != '1) r_op_cnt <= r_op_cnt + 1'b1;
            end
        end
    end

    assign O_VALID = (r_state == ST_FULL);
    assign O       = r_o;
    assign O_COUT  = r_cout;
    assign O_TAG   = r_tag;
    assign OP_CNT  = r_op_cnt;

    // A waiting requester that keeps VALID must not change its payload.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_chk
        a_req_stable: assert property (@(posedge CLK) disable iff (!ASYNCRESETN)
            (REQ_VALID[gi] && !REQ_READY[gi]) |=>
            (!REQ_VALID[gi] || ($stable(REQ_OP[gi]) &&
                                $stable(REQ_I0[gi*W +: W]) &&
                                $stable(REQ_I1[gi*W +: W]))));
    end

endmodule

// File: tb/tb_addsub_share_arb.sv
module tb_addsub_share_arb;

    logic        CLK;
    logic        ASYNCRESETN;
    logic [3:0]  REQ_VALID;
    logic [3:0]  REQ_READY;
    logic [3:0]  REQ_OP;
    logic [31:0] REQ_I0;
    logic [31:0] REQ_I1;
    logic        O_VALID;
    logic        O_READY;
    logic [7:0]  O;
    logic        O_COUT;
    logic [1:0]  O_TAG;
    logic [15:0] OP_CNT;

    addsub_share_arb #(.W(8), .NREQ(4), .TAGW(2), .CNTW(16)) dut (
        .CLK(CLK), .ASYNCRESETN(ASYNCRESETN),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OP(REQ_OP),
        .REQ_I0(REQ_I0), .REQ_I1(REQ_I1),
        .O_VALID(O_VALID), .O_READY(O_READY), .O(O), .O_COUT(O_COUT),
        .O_TAG(O_TAG), .OP_CNT(OP_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // per-requester payloads
    logic       top [4];
    logic [7:0] ta  [4];
    logic [7:0] tb_ [4];

    always_comb begin
        REQ_OP = '0;
        REQ_I0 = '0;
        REQ_I1 = '0;
        for (int i = 0; i < 4; i++) begin
            REQ_OP[i]       = top[i];
            REQ_I0[i*8 +: 8] = ta[i];
            REQ_I1[i*8 +: 8] = tb_[i];
        end
    end

    // reference model state
    bit       m_valid;
    int       m_o;
    bit       m_cout;
    int       m_tag;
    int       m_ptr;
    int       m_cnt;

    int nassert = 0;
    int nfail   = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nassert++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 0; m_o = 0; m_cout = 0; m_tag = 0; m_ptr = 0; m_cnt = 0;
    endtask

    task automatic new_payload(int i);
        top[i] = 1'($urandom_range(0, 1));
        ta[i]  = 8'($urandom_range(0, 255));
        tb_[i] = 8'($urandom_range(0, 255));
    endtask

    // One clock: check READY before the edge, advance model, check outputs after.
    task automatic step();
        logic [3:0] er;
        int  g;
        bit  found;
        int  s;
        #1;
        found = 0;
        g = 0;
        for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_ptr + k) % 4;
            if (!found && REQ_VALID[idx]) begin
                found = 1;
                g = idx;
            end
        end
        er = (found && (!m_valid || O_READY)) ? 4'(1 << g) : 4'b0;
        chk("req_ready", {28'b0, REQ_READY}, {28'b0, er});
        @(posedge CLK);
        if (er != 4'b0) begin
            if (top[g]) begin
                s = int'(ta[g]) - int'(tb_[g]);
                m_cout = (ta[g] >= tb_[g]);
                m_o = (s + 256) % 256;
            end else begin
                s = int'(ta[g]) + int'(tb_[g]);
                m_cout = (s > 255);
                m_o = s % 256;
            end
            m_valid = 1;
            m_tag = g;
            m_ptr = (g + 1) % 4;
            if (m_cnt != 65535) m_cnt++;
        end else if (m_valid && O_READY) begin
            m_valid = 0;
        end
        #1;
        if (er != 4'b0) new_payload(g);
        chk("o_valid", {31'b0, O_VALID}, {31'b0, m_valid});
        chk("o",       {24'b0, O},       32'(m_o));
        chk("o_cout",  {31'b0, O_COUT},  {31'b0, m_cout});
        chk("o_tag",   {30'b0, O_TAG},   32'(m_tag));
        chk("op_cnt",  {16'b0, OP_CNT},  32'(m_cnt));
    endtask

    initial begin
        for (int i = 0; i < 4; i++) new_payload(i);
        top[0] = 1'b0; ta[0] = 8'hFF; tb_[0] = 8'h01;
        top[2] = 1'b1; ta[2] = 8'h05; tb_[2] = 8'h07;
        model_reset();

        // reset state, READY held low even with all requesters valid
        ASYNCRESETN = 1'b0;
        O_READY     = 1'b1;
        REQ_VALID   = 4'hF;
        #12;
        chk("rst_ready", {28'b0, REQ_READY}, 32'h0);
        chk("rst_valid", {31'b0, O_VALID},   32'h0);
        chk("rst_o",     {24'b0, O},         32'h0);
        chk("rst_cout",  {31'b0, O_COUT},    32'h0);
        chk("rst_tag",   {30'b0, O_TAG},     32'h0);
        chk("rst_cnt",   {16'b0, OP_CNT},    32'h0);
        @(posedge CLK);
        #1;
        ASYNCRESETN = 1'b1;

        // requester 0: FF + 01
        REQ_VALID = 4'b0001;
        step();
        chk("add_o",    {24'b0, O},      32'h00);
        chk("add_cout", {31'b0, O_COUT}, 32'h1);
        chk("add_tag",  {30'b0, O_TAG},  32'h0);
        chk("add_cnt",  {16'b0, OP_CNT}, 32'h1);

        // requester 2: 05 - 07, then 07 - 05
        REQ_VALID = 4'b0100;
        step();
        chk("sub1_o",    {24'b0, O},      32'hFE);
        chk("sub1_cout", {31'b0, O_COUT}, 32'h0);
        chk("sub1_tag",  {30'b0, O_TAG},  32'h2);
        top[2] = 1'b1; ta[2] = 8'h07; tb_[2] = 8'h05;
        step();
        chk("sub2_o",    {24'b0, O},      32'h02);
        chk("sub2_cout", {31'b0, O_COUT}, 32'h1);

        // requester 3 alone brings the pointer back to 0
        REQ_VALID = 4'b1000;
        step();

        // all four valid: grants 0,1,2,3,0 back to back
        REQ_VALID = 4'hF;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_tag",   {30'b0, O_TAG},   32'(k % 4));
            chk("rr_valid", {31'b0, O_VALID}, 32'h1);
        end

        // backpressure with requester 1 waiting
        REQ_VALID = 4'b0010;
        O_READY   = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_tag", {30'b0, O_TAG}, 32'h0);
        end
        O_READY = 1'b1;
        step();
        chk("drain_accept_valid", {31'b0, O_VALID}, 32'h1);
        chk("drain_accept_tag",   {30'b0, O_TAG},   32'h1);

        // asynchronous reset in the middle of a cycle while full
        O_READY   = 1'b0;
        REQ_VALID = 4'b0110;
        #3;
        ASYNCRESETN = 1'b0;
        #1;
        chk("arst_valid", {31'b0, O_VALID},   32'h0);
        chk("arst_o",     {24'b0, O},         32'h0);
        chk("arst_cnt",   {16'b0, OP_CNT},    32'h0);
        chk("arst_ready", {28'b0, REQ_READY}, 32'h0);
        model_reset();
        #2;
        ASYNCRESETN = 1'b1;
        O_READY     = 1'b1;
        step();
        chk("post_rst_tag", {30'b0, O_TAG}, 32'h1);

        // randomized traffic
        for (int k = 0; k < 300; k++) begin
            REQ_VALID = 4'($urandom_range(0, 15));
            O_READY   = ($urandom_range(0, 3) != 0);
            step();
        end

        // counter saturation
        REQ_VALID = 4'b0000;
        O_READY   = 1'b1;
        step();
        force dut.r_op_cnt = 16'hFFFE;
        #1;
        release dut.r_op_cnt;
        m_cnt = 65534;
        chk("cnt_preset", {16'b0, OP_CNT}, 32'hFFFE);
        REQ_VALID = 4'b0001;
        for (int k = 0; k < 3; k++) step();
        chk("cnt_sat", {16'b0, OP_CNT}, 32'hFFFF);
        REQ_VALID = 4'b0000;
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
        $finish;
    end

endmodule

// File: doc/addsub_share_arb.md
Name: addsub_share_arb

Overview:
- Time-shares one W-bit add/subtract datapath (I0 + (OP ? ~I1 : I1) + OP, carry-in form) between NREQ requesters.
- Round-robin arbitration with per-requester valid/ready handshake.
- Single registered result stage with tag and backpressure.
- Sits between requester ports and the arithmetic core; replaces per-requester adder instances.

Parameters:
- W, 8, operand/result width in bits.
- NREQ, 4, number of requesters (2..16).
- TAGW, 2, requester tag width; must equal max(1, clog2(NREQ)).
- CNTW, 16, width of the accepted-operation counter.

Ports:
- CLK  input  1  rising-edge clock
- ASYNCRESETN  input  1  asynchronous active-low reset
- REQ_VALID  input  NREQ  bit i: requester i presents an operation
- REQ_READY  output  NREQ  bit i: requester i's operation is accepted this cycle
- REQ_OP  input  NREQ  bit i: 0 = add, 1 = subtract (I0 - I1)
- REQ_I0  input  NREQ*W  operand A; requester i occupies bits [i*W +: W]
- REQ_I1  input  NREQ*W  operand B; same packing
- O_VALID  output  1  result register holds a valid result
- O_READY  input  1  downstream accepts result
- O  output  W  result
- O_COUT  output  1  carry out of the W-bit sum (subtract: 1 = no borrow)
- O_TAG  output  TAGW  index of the requester that produced O
- OP_CNT  output  CNTW  saturating count of accepted operations

Behaviour:
- Reset (ASYNCRESETN=0, effective immediately, no clock needed):
  - O_VALID=0, O=0, O_COUT=0, O_TAG=0, OP_CNT=0, RR pointer=0.
  - REQ_READY=0 while reset is asserted.
  - A result pending at reset is discarded.
- States, derived from O_VALID:
  - EMPTY (O_VALID=0).
  - FULL (O_VALID=1).
  - can_accept = !O_VALID | O_READY (combinational).
- Arbitration (combinational):
  - Search REQ_VALID starting at the RR pointer, ascending, wrapping at NREQ-1 -> 0.
  - The first set bit g is the grant.
  - REQ_READY = one-hot(g) & can_accept; all-zero if no REQ_VALID bit is set.
  - REQ_READY never depends on REQ_OP or operands.
- Transfer:
  - A requester handshake occurs when REQ_VALID[g] & REQ_READY[g].
  - On that edge: O = low W bits of {1'b0,I0} + {1'b0,OP ? ~I1 : I1} + OP; O_COUT = bit W of that sum; O_TAG = g; O_VALID = 1; pointer = (g+1) mod NREQ.
  - Latency: exactly 1 cycle from handshake edge to O_VALID.
- Output handshake:
  - Completes when O_VALID & O_READY.
  - With no simultaneous requester handshake: O_VALID -> 0 next edge; O, O_COUT and O_TAG hold their last values.
  - Simultaneous drain and accept on the same edge: the new result replaces the old, O_VALID stays 1. Sustained throughput is 1 op/cycle.
- FULL & !O_READY:
  - REQ_READY all zero.
  - O, O_COUT and O_TAG held stable; pointer unchanged.
- Pointer:
  - Advances only on a requester handshake, never on idle cycles.
  - A requester that holds REQ_VALID is served within NREQ handshakes.
- OP_CNT:
  - +1 per requester handshake.
  - Saturates at 2^CNTW-1, no wrap.
- Requester rule (checked by assertion): once REQ_VALID[i] is raised, REQ_OP and the operands for i stay stable until REQ_READY[i]. The arbiter does not rely on this rule for correctness.

Test Plan:
- Reset, then requester 0 sends add 8'hFF + 8'h01 with O_READY=1. Required: REQ_READY=4'b0001 that cycle; next cycle O=8'h00, O_COUT=1, O_TAG=0, O_VALID=1; OP_CNT=1.
- Requester 2 sends subtract 8'h05 - 8'h07. Required: O=8'hFE, O_COUT=0, O_TAG=2. Then 8'h07 - 8'h05: O=8'h02, O_COUT=1.
- All four REQ_VALID held high, O_READY=1, pointer starting at 0. Required: grants 0,1,2,3,0 on consecutive cycles; O_VALID continuously 1 from cycle 1; O_TAG sequence 0,1,2,3,0.
- Hold O_READY=0 for 3 cycles with O_VALID=1. Required: REQ_READY=0, O/O_TAG unchanged, pointer unchanged. Raise O_READY with requester 1 valid: drain and new accept on the same edge, O_VALID stays 1.
- Pull ASYNCRESETN low mid-cycle with O_VALID=1. Required: O_VALID, OP_CNT and O drop to 0 before the next CLK edge. After release, the first grant goes to the lowest-index valid requester.
- Force OP_CNT to 16'hFFFE, then complete 3 handshakes. Required: OP_CNT reads 16'hFFFF and stays there.
